// File: rtl/fetch_stage_if.sv
// Signal bundle between the Y86-64 fetch stage and its surroundings:
// pipeline control and redirect inputs, the instruction memory port, and the f_* decode bundle.
interface fetch_stage_if;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;

    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;

    logic [63:0] f_pc;
    logic [2:0]  f_stat;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [63:0] f_predPC;
    logic        f_halted;

    modport master (
        input  F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM,
        input  imem_data, imem_error,
        output imem_addr,
        output f_pc, f_stat, f_icode, f_ifun, f_rA, f_rB,
        output f_valC, f_valP, f_predPC, f_halted
    );

    modport slave (
        output F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM,
        output imem_data, imem_error,
        input  imem_addr,
        input  f_pc, f_stat, f_icode, f_ifun, f_rA, f_rB,
        input  f_valC, f_valP, f_predPC, f_halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC selection, 10-byte instruction window decode, PC prediction,
// and a halted sub-state that stops fetching until a mispredict/ret redirect or reset.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          NUM_FREGS = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master fif
);
    localparam logic [3:0] RNONE    = 4'(NUM_FREGS);
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t      state_q, state_d;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] pred_pc_q, pred_pc_d;

    logic        mispredict, ret_redirect, redirect, halted;
    logic [63:0] pc;
    logic [3:0]  icode, ifun;
    logic        instr_valid, need_regids, need_valc;
    logic [63:0] dec_valc, dec_valp, dec_predpc;
    logic [2:0]  dec_stat;

    logic [7:0]  win_b [10];
    logic [63:0] valc_lo, valc_hi;

    for (genvar gi = 0; gi < 10; gi++) begin : g_bytes
        assign win_b[gi] = fif.imem_data[8*gi +: 8];
    end

    // Constant word sits at byte 1 without a register byte, at byte 2 with one.
    for (genvar gi = 0; gi < 8; gi++) begin : g_valc
        assign valc_lo[8*gi +: 8] = win_b[gi+1];
        assign valc_hi[8*gi +: 8] = win_b[gi+2];
    end

    assign mispredict   = (fif.M_icode == I_JXX) && !fif.M_Cnd;
    assign ret_redirect = (fif.W_icode == I_RET);
    assign redirect     = mispredict || ret_redirect;
    assign pc           = mispredict   ? fif.M_valA :
                          ret_redirect ? fif.W_valM : pred_pc_q;
    assign halted       = (state_q == ST_HALTED);

    assign icode = fif.imem_error ? I_NOP : win_b[0][7:4];
    assign ifun  = fif.imem_error ? 4'h0  : win_b[0][3:0];

    always_comb begin
        instr_valid = 1'b0;
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: instr_valid = (ifun == 4'h0);
            I_RRMOVQ: begin
                need_regids = 1'b1;
                instr_valid = (ifun <= 4'd6);
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
                instr_valid = (ifun == 4'h0);
            end
            I_OPQ: begin
                need_regids = 1'b1;
                instr_valid = (ifun <= 4'd3);
            end
            I_JXX: begin
                need_valc   = 1'b1;
                instr_valid = (ifun <= 4'd6);
            end
            I_CALL: begin
                need_valc   = 1'b1;
                instr_valid = (ifun == 4'h0);
            end
            I_PUSHQ, I_POPQ: begin
                need_regids = 1'b1;
                instr_valid = (ifun == 4'h0);
            end
            default: instr_valid = 1'b0;
        endcase
    end

    assign dec_valc   = !need_valc  ? 64'd0 :
                        need_regids ? valc_hi : valc_lo;
    assign dec_valp   = pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
    assign dec_predpc = (icode == I_JXX || icode == I_CALL) ? dec_valc : dec_valp;
    assign dec_stat   = fif.imem_error   ? S_ADR :
                        !instr_valid     ? S_INS :
                        (icode == I_HALT) ? S_HLT : S_AOK;

    assign fif.imem_addr = pc;
    assign fif.f_pc      = pc;
    assign fif.f_stat    = halted ? stat_q : dec_stat;
    assign fif.f_icode   = halted ? I_NOP  : icode;
    assign fif.f_ifun    = halted ? 4'h0   : ifun;
    assign fif.f_rA      = (!halted && need_regids) ? win_b[1][7:4] : RNONE;
    assign fif.f_rB      = (!halted && need_regids) ? win_b[1][3:0] : RNONE;
    assign fif.f_valC    = halted ? 64'd0 : dec_valc;
    assign fif.f_valP    = dec_valp;
    assign fif.f_predPC  = dec_predpc;
    assign fif.f_halted  = halted;

    // A stall freezes everything, including a pending redirect out of HALTED.
    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        pred_pc_d = pred_pc_q;
        if (!fif.F_stall) begin
            if (state_q == ST_RUN) begin
                if (dec_stat != S_AOK) begin
                    state_d = ST_HALTED;
                    stat_d  = dec_stat;
                end else begin
                    pred_pc_d = dec_predpc;
                end
            end else if (redirect) begin
                state_d   = ST_RUN;
                stat_d    = S_AOK;
                pred_pc_d = dec_predpc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            stat_q    <= S_AOK;
            pred_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            pred_pc_q <= pred_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an instruction-length-table model predicts every output
// each cycle, and literal expectations pin the directed scenarios.
`timescale 1ns/1ps
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if fif();

    fetch_stage #(.RESET_PC(64'd0), .NUM_FREGS(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fif  (fif)
    );

    logic [7:0] mem [4096];
    logic       err_force;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         cmp_en = 1'b0;

    always_comb begin
        fif.imem_data = '0;
        for (int i = 0; i < 10; i++)
            fif.imem_data[8*i +: 8] = mem[fif.imem_addr[11:0] + 12'(i)];
    end
    assign fif.imem_error = err_force;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] predpc;
        logic [63:0] pc;
    } exp_t;

    logic [63:0] m_pred;
    logic        m_halted;
    logic [2:0]  m_stat;
    exp_t        exp_now;

    function automatic logic [7:0] mbyte(input logic [63:0] a, input int k);
        logic [11:0] idx;
        idx = a[11:0] + 12'(k);
        return mem[idx];
    endfunction

    function automatic exp_t model_eval();
        exp_t        e;
        int          len, maxfun;
        logic [7:0]  b0, b1;
        logic [3:0]  ic, fn;
        logic [63:0] p, c;
        if (fif.M_icode == 4'd7 && !fif.M_Cnd) p = fif.M_valA;
        else if (fif.W_icode == 4'd9)          p = fif.W_valM;
        else                                   p = m_pred;
        b0 = mbyte(p, 0);
        b1 = mbyte(p, 1);
        ic = b0[7:4];
        fn = b0[3:0];
        if (err_force) begin ic = 4'd1; fn = 4'd0; end
        case (ic)
            4'd2, 4'd6, 4'd10, 4'd11: len = 2;
            4'd3, 4'd4, 4'd5:         len = 10;
            4'd7, 4'd8:               len = 9;
            default:                  len = 1;
        endcase
        case (ic)
            4'd2, 4'd7: maxfun = 6;
            4'd6:       maxfun = 3;
            default:    maxfun = 0;
        endcase
        c = 64'd0;
        if (len >= 9)
            for (int k = 0; k < 8; k++) c[8*k +: 8] = mbyte(p, len - 8 + k);
        e.pc     = p;
        e.icode  = ic;
        e.ifun   = fn;
        e.valc   = c;
        e.valp   = p + 64'(len);
        e.predpc = (ic == 4'd7 || ic == 4'd8) ? c : e.valp;
        e.ra     = (len == 2 || len == 10) ? b1[7:4] : 4'hF;
        e.rb     = (len == 2 || len == 10) ? b1[3:0] : 4'hF;
        if (err_force)                              e.stat = 3'd3;
        else if (ic > 4'd11 || int'(fn) > maxfun)   e.stat = 3'd4;
        else if (ic == 4'd0)                        e.stat = 3'd2;
        else                                        e.stat = 3'd1;
        if (m_halted) begin
            e.stat  = m_stat;
            e.icode = 4'd1;
            e.ifun  = 4'd0;
            e.ra    = 4'hF;
            e.rb    = 4'hF;
            e.valc  = 64'd0;
        end
        return e;
    endfunction

    always_comb exp_now = model_eval();

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model state: a redirect only matters for leaving the halted sub-state.
    initial begin
        m_pred = 64'd0; m_halted = 1'b0; m_stat = 3'd1;
        forever begin
            exp_t e;
            @(posedge clk or negedge rst_n);
            e = exp_now;
            if (!rst_n) begin
                m_pred = 64'd0; m_halted = 1'b0; m_stat = 3'd1;
            end else if (!fif.F_stall) begin
                if (!m_halted) begin
                    if (e.stat != 3'd1) begin m_halted = 1'b1; m_stat = e.stat; end
                    else m_pred = e.predpc;
                end else if ((fif.M_icode == 4'd7 && !fif.M_Cnd) || fif.W_icode == 4'd9) begin
                    m_halted = 1'b0;
                    m_pred   = e.predpc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && rst_n) begin
                chk("cyc_pc",     fif.f_pc,              exp_now.pc);
                chk("cyc_stat",   64'(fif.f_stat),       64'(exp_now.stat));
                chk("cyc_icode",  64'(fif.f_icode),      64'(exp_now.icode));
                chk("cyc_ifun",   64'(fif.f_ifun),       64'(exp_now.ifun));
                chk("cyc_rA",     64'(fif.f_rA),         64'(exp_now.ra));
                chk("cyc_rB",     64'(fif.f_rB),         64'(exp_now.rb));
                chk("cyc_valC",   fif.f_valC,            exp_now.valc);
                chk("cyc_valP",   fif.f_valP,            exp_now.valp);
                chk("cyc_predPC", fif.f_predPC,          exp_now.predpc);
                chk("cyc_halted", 64'(fif.f_halted),     64'(m_halted));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string what);
        $display("txn t=%0t %s pc=0x%0h stat=%0d icode=%0h halted=%0b",
                 $time, what, fif.f_pc, fif.f_stat, fif.f_icode, fif.f_halted);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[0]     = 8'h30; mem[1]     = 8'hF3; mem[2]     = 8'h0A;
        mem[10]    = 8'h70; mem[11]    = 8'h00; mem[12]    = 8'h01;
        mem[19]    = 8'h10;
        mem[12'h040] = 8'h60; mem[12'h041] = 8'h01;
        mem[12'h042] = 8'h65; mem[12'h043] = 8'h01;
        mem[12'h080] = 8'h30; mem[12'h081] = 8'hF2; mem[12'h082] = 8'h05;
        mem[12'h08A] = 8'h10; mem[12'h08B] = 8'h10;
        mem[12'hFFE] = 8'h30; mem[12'hFFF] = 8'hF1;

        err_force   = 1'b0;
        fif.F_stall = 1'b0;
        fif.M_icode = 4'd0; fif.M_Cnd = 1'b0; fif.M_valA = 64'd0;
        fif.W_icode = 4'd0; fif.W_valM = 64'd0;
        rst_n = 1'b0;
        #1;
        chk("rst_pc",     fif.f_pc, 64'd0);
        chk("rst_halted", 64'(fif.f_halted), 64'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; cmp_en = 1'b1; #1;
        txn("reset irmovq");
        chk("pc0_stat",   64'(fif.f_stat), 64'd1);
        chk("pc0_icode",  64'(fif.f_icode), 64'd3);
        chk("pc0_ifun",   64'(fif.f_ifun), 64'd0);
        chk("pc0_rA",     64'(fif.f_rA), 64'hF);
        chk("pc0_rB",     64'(fif.f_rB), 64'd3);
        chk("pc0_valC",   fif.f_valC, 64'd10);
        chk("pc0_valP",   fif.f_valP, 64'd10);
        chk("pc0_predPC", fif.f_predPC, 64'd10);

        step(); #1; txn("jmp");
        chk("jmp_pc",     fif.f_pc, 64'd10);
        chk("jmp_valC",   fif.f_valC, 64'h100);
        chk("jmp_valP",   fif.f_valP, 64'd19);
        chk("jmp_predPC", fif.f_predPC, 64'h100);

        fif.M_icode = 4'd7; fif.M_Cnd = 1'b0; fif.M_valA = 64'd19;
        fif.W_icode = 4'd9; fif.W_valM = 64'h500;
        #1; txn("mispredict+ret");
        chk("mp_wins_pc", fif.f_pc, 64'd19);

        step(); fif.M_icode = 4'd0; fif.W_icode = 4'd0; #1; txn("halt insn");
        chk("halt_pc",   fif.f_pc, 64'd20);
        chk("halt_stat", 64'(fif.f_stat), 64'd2);

        for (int i = 0; i < 3; i++) begin
            step(); #1; txn("halted hold");
            chk("hold_halted", 64'(fif.f_halted), 64'd1);
            chk("hold_icode",  64'(fif.f_icode), 64'd1);
            chk("hold_stat",   64'(fif.f_stat), 64'd2);
            chk("hold_pc",     fif.f_pc, 64'd20);
        end

        fif.W_icode = 4'd9; fif.W_valM = 64'h40; #1; txn("ret redirect");
        chk("ret_pc",    fif.f_pc, 64'h40);
        chk("ret_icode", 64'(fif.f_icode), 64'd1);
        step(); fif.W_icode = 4'd0; #1; txn("bad OPq");
        chk("exit_halted", 64'(fif.f_halted), 64'd0);
        chk("exit_pc",     fif.f_pc, 64'h42);
        chk("ins_stat",    64'(fif.f_stat), 64'd4);
        step(); #1; txn("halted INS");
        chk("ins_halted",  64'(fif.f_halted), 64'd1);
        chk("ins_latched", 64'(fif.f_stat), 64'd4);

        fif.F_stall = 1'b1;
        fif.M_icode = 4'd7; fif.M_Cnd = 1'b0; fif.M_valA = 64'h80;
        for (int i = 0; i < 2; i++) begin
            step(); #1; txn("stall over redirect");
            chk("stall_halted", 64'(fif.f_halted), 64'd1);
            chk("stall_pc",     fif.f_pc, 64'h80);
        end
        fif.F_stall = 1'b0; #1;
        step(); fif.M_icode = 4'd0; #1; txn("stall released");
        chk("rel_halted", 64'(fif.f_halted), 64'd0);
        chk("rel_pc",     fif.f_pc, 64'h8A);

        fif.F_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); #1; txn("run stall");
            chk("runstall_pc", fif.f_pc, 64'h8A);
        end
        fif.F_stall = 1'b0;
        step(); #1; txn("run resume");
        chk("resume_pc", fif.f_pc, 64'h8B);

        fif.M_icode = 4'd7; fif.M_Cnd = 1'b0; fif.M_valA = 64'hFFFF_FFFF_FFFF_FFFE; #1;
        txn("wrap");
        chk("wrap_valP", fif.f_valP, 64'd8);
        chk("wrap_valC", fif.f_valC, 64'h0000_0000_000A_F330);
        step(); fif.M_icode = 4'd0; #1;
        chk("wrap_pc", fif.f_pc, 64'd8);
        fif.M_icode = 4'd7; fif.M_Cnd = 1'b1; fif.M_valA = 64'h123; #1;
        txn("taken jXX no redirect");
        chk("taken_pc", fif.f_pc, 64'd8);
        fif.M_icode = 4'd0; fif.M_Cnd = 1'b0;

        err_force = 1'b1; #1; txn("imem error");
        chk("adr_stat",  64'(fif.f_stat), 64'd3);
        chk("adr_icode", 64'(fif.f_icode), 64'd1);
        chk("adr_valP",  fif.f_valP, 64'd9);
        step(); #1; txn("halted ADR");
        chk("adr_halted", 64'(fif.f_halted), 64'd1);
        chk("adr_latch",  64'(fif.f_stat), 64'd3);

        rst_n = 1'b0; #1;
        err_force = 1'b0;
        txn("async reset");
        chk("arst_halted", 64'(fif.f_halted), 64'd0);
        chk("arst_pc",     fif.f_pc, 64'd0);
        #1; rst_n = 1'b1;
        step(); #1; txn("after reset");
        chk("post_rst_pc", fif.f_pc, 64'd10);
        step(); #1;
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
